// File: rtl/mem_ctrl_pkg.sv
// Shared types for the buffered memory controller: FSM state encoding,
// access-size width and the packed request-entry width.
package mem_ctrl_pkg;

  localparam int SIZE_W = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RD  = 2'd1,
    WAIT_RDY = 2'd2
  } state_t;

  // One FIFO entry is {write, size, addr, data}.
  function automatic int req_width(input int addr_w, input int data_w);
    return 1 + SIZE_W + addr_w + data_w;
  endfunction

endpackage

// File: rtl/mem_ctrl_buf_req_fifo.sv
// Synchronous request FIFO with a combinational head read. DEPTH must be a
// power of two so the pointers wrap naturally.
module req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     I_clk,
  input  logic                     I_reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push is refused when full, even if a pop frees a slot this cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  always_ff @(posedge I_clk) begin
    if (!I_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge I_clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/mem_ctrl_buf.sv
// Buffered memory controller: CPU requests are queued in req_fifo and issued
// in order to the memory port. Optional read timeout via MEM_CTRL_TIMEOUT_EN.
module mem_ctrl_buf
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              I_clk,
  input  logic              I_reset,
  input  logic              I_exec,
  input  logic              I_write,
  input  logic [SIZE_W-1:0] I_size,
  input  logic [ADDR_W-1:0] I_addr,
  input  logic [DATA_W-1:0] I_data,
  output logic              O_ready,
  output logic [DATA_W-1:0] O_data,
  output logic              O_data_ready,
  output logic              O_busy,
  output logic              O_error,
  input  logic              MEM_ready,
  output logic              MEM_exec,
  output logic              MEM_write,
  output logic [ADDR_W-1:0] MEM_addr,
  output logic [SIZE_W-1:0] MEM_size,
  output logic [DATA_W-1:0] MEM_data_out,
  input  logic [DATA_W-1:0] MEM_data_in,
  input  logic              MEM_data_ready
);

  localparam int REQ_W = req_width(ADDR_W, DATA_W);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  state_t            state;
  state_t            next_state;
  logic [REQ_W-1:0]  req_in;
  logic [REQ_W-1:0]  req_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              issue;
  logic              capture;
  logic              timeout_hit;

  assign req_in = {I_write, I_size, I_addr, I_data};

  req_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (DEPTH)
  ) u_req_fifo (
    .I_clk   (I_clk),
    .I_reset (I_reset),
    .push    (I_exec),
    .pop     (issue),
    .wdata   (req_in),
    .rdata   (req_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign O_ready = !fifo_full;
  assign O_busy  = (fifo_count != '0) || (state != IDLE);

  always_ff @(posedge I_clk) begin
    if (!I_reset) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (issue) next_state = req_head[REQ_W-1] ? WAIT_RDY : WAIT_RD;
      WAIT_RD:  if (MEM_data_ready || timeout_hit) next_state = WAIT_RDY;
      WAIT_RDY: if (MEM_ready) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

`ifdef MEM_CTRL_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge I_clk) begin
    if (!I_reset)             to_cnt <= '0;
    else if (issue)           to_cnt <= '0;
    else if (state == WAIT_RD) to_cnt <= to_cnt + TO_W'(1);
  end
`endif

  // Real read data arriving on the timeout cycle takes priority over the error.
  always_comb begin
    issue   = (state == IDLE) && !fifo_empty && MEM_ready;
    capture = (state == WAIT_RD) && MEM_data_ready;
`ifdef MEM_CTRL_TIMEOUT_EN
    timeout_hit = (state == WAIT_RD) && !MEM_data_ready &&
                  (to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
    timeout_hit = 1'b0;
`endif
  end

  always_ff @(posedge I_clk) begin
    if (!I_reset) begin
      MEM_exec     <= 1'b0;
      MEM_write    <= 1'b0;
      MEM_addr     <= '0;
      MEM_size     <= '0;
      MEM_data_out <= '0;
      O_data       <= '0;
      O_data_ready <= 1'b0;
    end else begin
      MEM_exec     <= issue;
      O_data_ready <= capture || timeout_hit;
      if (issue) begin
        MEM_write    <= req_head[REQ_W-1];
        MEM_size     <= req_head[REQ_W-2 -: SIZE_W];
        MEM_addr     <= req_head[DATA_W +: ADDR_W];
        MEM_data_out <= req_head[DATA_W-1:0];
      end
      if (capture)          O_data <= MEM_data_in;
      else if (timeout_hit) O_data <= '1;
    end
  end

`ifdef MEM_CTRL_TIMEOUT_EN
  always_ff @(posedge I_clk) begin
    if (!I_reset) O_error <= 1'b0;
    else          O_error <= timeout_hit;
  end
`else
  assign O_error = 1'b0;
`endif

endmodule

// File: doc/mem_ctrl_buf.md
Name: mem_ctrl_buf

Overview:
- Parametrised successor to the single-request memory controller: decouples CPU-side requests from the memory port through a DEPTH-entry request FIFO.
- Writes are posted and complete without stalling the CPU. Reads are queued in order behind earlier writes and return data with a one-cycle O_data_ready pulse.
- Sits between the CPU load/store unit and the memory/bus interface. The memory-side handshake is unchanged from the current controller.

Parameters:
- DATA_W, 16, width of the data paths.
- ADDR_W, 16, width of the address.
- DEPTH, 4, request FIFO entries; must be a power of 2 and at least 2.
- TIMEOUT_CYC, 255, read timeout in cycles; used only with MEM_CTRL_TIMEOUT_EN.

Ports:
- I_clk  in  1  clock
- I_reset  in  1  reset; synchronous, active-low
- I_exec  in  1  request valid; accepted on a rising edge when O_ready=1
- I_write  in  1  1=write, 0=read
- I_size  in  2  access size code, passed through unchanged
- I_addr  in  ADDR_W  request address
- I_data  in  DATA_W  write data
- O_ready  out  1  FIFO not full; request can be accepted
- O_data  out  DATA_W  read data; holds its value until the next read completes
- O_data_ready  out  1  one-cycle pulse when O_data is valid
- O_busy  out  1  FIFO non-empty or FSM not in IDLE (used for fences)
- O_error  out  1  read timeout pulse; tied 0 when the feature is off
- MEM_ready  in  1  memory can accept or has finished
- MEM_exec  out  1  one-cycle memory request strobe
- MEM_write  out  1  write flag
- MEM_addr  out  ADDR_W  address
- MEM_size  out  2  size code
- MEM_data_out  out  DATA_W  write data
- MEM_data_in  in  DATA_W  read data
- MEM_data_ready  in  1  read data valid

Behaviour:
- Reset: I_reset=0 at a rising edge. All registered outputs go to 0, the FIFO is emptied, and the FSM enters IDLE. Reset mid-operation abandons the in-flight access and discards queued requests; no O_data_ready is generated for them.
- Accept: when I_exec=1 and O_ready=1, {write, size, addr, data} is pushed.
- O_ready = !full, driven combinationally from the count register. A push is refused when full even if a pop happens in the same cycle.
- Count is $clog2(DEPTH)+1 bits. Read/write pointers wrap modulo DEPTH.
- A simultaneous push and pop leaves the count unchanged.
- FSM states:
  - IDLE: if the FIFO is non-empty and MEM_ready=1, pop the head, register it onto the MEM_* outputs, set MEM_exec=1, and go to WAIT_RD (read) or WAIT_RDY (write). Otherwise stay in IDLE with MEM_exec=0.
  - WAIT_RD: MEM_exec=0. On MEM_data_ready=1, capture O_data<=MEM_data_in, pulse O_data_ready=1, go to WAIT_RDY.
  - WAIT_RDY: MEM_exec=0, O_data_ready=0. On MEM_ready=1, go to IDLE.
- MEM_addr, MEM_write, MEM_size and MEM_data_out are held stable from issue until the FSM returns to IDLE.
- Latency: with an empty FIFO and MEM_ready=1, a request accepted at edge k raises MEM_exec after edge k+1, high for exactly one cycle.
- Ordering: strictly FIFO, so a read never bypasses an older write.
- O_data_ready: never asserted for writes; at most one pulse per read.

Optional Feature:
- MEM_CTRL_TIMEOUT_EN defined:
  - A counter runs in WAIT_RD.
  - If TIMEOUT_CYC cycles pass without MEM_data_ready, the controller sets O_data to all ones, pulses O_data_ready and O_error together for one cycle, and goes to WAIT_RDY.
  - A MEM_data_ready arriving in the same cycle as the timeout wins: normal data is returned and there is no error.
- Not defined: no counter; O_error is tied to 0; WAIT_RD waits indefinitely.

Decomposition:
- mem_ctrl_pkg: FSM state encoding (IDLE, WAIT_RD, WAIT_RDY), SIZE_W=2, and a request-entry width function (1+SIZE_W+ADDR_W+DATA_W).
- Sub-module req_fifo: synchronous FIFO parametrised by WIDTH and DEPTH, with push/pop/full/empty/count outputs.

Test Plan:
- Single write 0x1234 to 0x0010 with MEM_ready=1: MEM_exec pulses once with matching addr/data; O_data_ready stays 0; O_busy clears once MEM_ready is seen in WAIT_RDY.
- Read 0x0020 with MEM_data_ready after 3 cycles carrying 0xBEEF: O_data=0xBEEF and a one-cycle O_data_ready pulse.
- Five back-to-back writes with DEPTH=4 and MEM_ready=0: O_ready drops after the 4th push; the 5th is held. Raising MEM_ready drains all 5 in order.
- Write 0x00AA to 0x0030, then immediately read 0x0030: the memory sees the write strictly before the read, and the read returns 0x00AA.
- Reset (I_reset=0) asserted in WAIT_RD with 2 entries queued: the next cycle has MEM_exec=0, O_ready=1, O_busy=0, and no O_data_ready.
- MEM_CTRL_TIMEOUT_EN with TIMEOUT_CYC=8 and MEM_data_ready never asserted: after 8 cycles O_data=0xFFFF, and O_data_ready and O_error pulse together.
